// File: rtl/hydra_sram_pkg.sv
// Shared defaults for the SRAM-backed queue blocks.
package hydra_sram_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/sram_fifo_skid.sv
// Two-entry output buffer; the head register drives the downstream port directly.
module sram_fifo_skid
    import hydra_sram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occupancy
);

    logic              tail_valid;
    logic [DATA_W-1:0] tail_data;

    // The upstream read-issue logic never sends a word unless a slot is free after this cycle's pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset too so out_data reads zero straight out of reset.
            head_valid <= 1'b0;
            head_data  <= '0;
            tail_valid <= 1'b0;
            tail_data  <= '0;
        end else if (pop) begin
            if (tail_valid) begin
                head_data  <= tail_data;
                tail_valid <= wr_valid;
                if (wr_valid) tail_data <= wr_data;
            end else begin
                head_valid <= wr_valid;
                if (wr_valid) head_data <= wr_data;
            end
        end else if (wr_valid) begin
            if (!head_valid) begin
                head_valid <= 1'b1;
                head_data  <= wr_data;
            end else begin
                tail_valid <= 1'b1;
                tail_data  <= wr_data;
            end
        end
    end

    assign occupancy = {1'b0, head_valid} + {1'b0, tail_valid};

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Queue controller using an external single-cycle SRAM as storage, with a
// 2-entry registered output buffer so the queue streams at one word per cycle.
module sram_fifo_ctrl
    import hydra_sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_wr_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   sram_cnt;
    logic              rd_inflight;
    logic [1:0]        buf_cnt;
    logic [2:0]        pending;
    logic              push;
    logic              pop;
    logic              rd_issue;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
    endfunction

    assign full     = (sram_cnt == DEPTH_CNT);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Words already promised to the buffer; a pop this cycle frees one more slot.
    // sram_cnt excludes this cycle's push, so a word is never read in its write cycle.
    assign pending  = {1'b0, buf_cnt} + {2'b00, rd_inflight};
    assign rd_issue = !rst && (sram_cnt != '0) && (pending < (pop ? 3'd3 : 3'd2));

    assign sram_wr_en   = push;
    assign sram_wr_addr = wr_ptr;
    assign sram_din     = in_data;
    assign sram_rd_en   = rd_issue;
    assign sram_rd_addr = rd_ptr;

    assign count = sram_cnt + (ADDR_W + 1)'(pending);
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sram_cnt    <= '0;
            rd_inflight <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every term reads the pre-edge state.
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (rd_issue) rd_ptr <= next_ptr(rd_ptr);
            sram_cnt    <= sram_cnt + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(rd_issue);
            rd_inflight <= rd_issue;
        end
    end

    sram_fifo_skid #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (rd_inflight),
        .wr_data   (sram_dout),
        .pop       (pop),
        .head_valid(out_valid),
        .head_data (out_data),
        .occupancy (buf_cnt)
    );

endmodule
